// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing defaults and the TX/RX state types.
package uart_pkg;

    localparam int BAUD_DIV = 109;
    localparam int HALF_BIT = 54;
    localparam int TIMEOUT  = 2048;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // Places a received byte into the cmd field chosen by the byte index.
    function automatic logic [23:0] cmd_insert(input logic [23:0] cur,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
        logic [23:0] r;
        r = cur;
        case (idx)
            2'd0:    r[23:16] = b;
            2'd1:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizer, edge detect, mid-bit sampling FSM.
// Strobes are combinational from the sample cycle; the parent registers them.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BAUD = BAUD_DIV,
    parameter int HALF = HALF_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frm_err,
    output logic       rx_edge,
    output logic       rx_start,
    output logic       rx_idle
);

    localparam int CW = $clog2(BAUD);

    logic [2:0]    sync;
    logic          line;
    rx_state_t     state, state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          samp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 3'b111;
        else        sync <= {sync[1:0], rx};
    end

    assign line    = sync[1];
    assign rx_edge = (state == IDLE) && sync[2] && !sync[1];
    assign rx_idle = (state == IDLE);
    assign rx_data = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        samp       = 1'b0;
        rx_valid   = 1'b0;
        rx_frm_err = 1'b0;
        rx_start   = 1'b0;
        case (state)
            IDLE: if (rx_edge) state_nxt = START;
            START: if (baud_cnt == CW'(HALF - 1)) begin
                samp = 1'b1;
                if (!line) begin
                    state_nxt = DATA;
                    rx_start  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: if (baud_cnt == CW'(BAUD - 1)) begin
                samp = 1'b1;
                if (bit_cnt == 3'd7) state_nxt = STOP;
            end
            STOP: if (baud_cnt == CW'(BAUD - 1)) begin
                // Return to IDLE mid stop bit so a back-to-back start edge is seen.
                samp       = 1'b1;
                rx_valid   = line;
                rx_frm_err = !line;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (state == IDLE) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (samp) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (state == DATA && samp) begin
                shreg   <= {line, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Assembles three received bytes into a 24-bit command with ready/ack
// handshake, frame-error reporting and partial-command timeout.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int BAUD = BAUD_DIV,
    parameter int HALF = HALF_BIT,
    parameter int TMO  = TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err
);

    localparam int TW = $clog2(TMO);

    logic [7:0]    rx_data;
    logic          rx_valid, rx_frm_err, rx_edge, rx_start, rx_idle;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_run, tmo_hit, set_rdy;

    uart_rx_byte #(.BAUD(BAUD), .HALF(HALF)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (RX),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_frm_err (rx_frm_err),
        .rx_edge    (rx_edge),
        .rx_start   (rx_start),
        .rx_idle    (rx_idle)
    );

    assign tmo_run = (byte_cnt != 2'd0) && rx_idle && !rx_edge;
    assign tmo_hit = tmo_run && (tmo_cnt == TW'(TMO - 1));
    assign set_rdy = rx_valid && (byte_cnt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            cmd      <= '0;
        end else if (rx_frm_err) begin
            byte_cnt <= 2'd0;
        end else if (rx_valid) begin
            cmd      <= cmd_insert(cmd, byte_cnt, rx_data);
            byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
        end else if (tmo_hit) begin
            byte_cnt <= 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             tmo_cnt <= '0;
        else if (!tmo_run)      tmo_cnt <= '0;
        else if (tmo_hit)       tmo_cnt <= '0;
        else                    tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Set has priority over both clear sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_rdy <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            frm_err <= rx_frm_err;
            if (set_rdy)                       cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || rx_start)  cmd_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial frames driven at 109 clocks/bit,
// expected commands queued at send time and checked when cmd_rdy rises.
module tb_uart_cmd_rx;

    localparam int BAUD    = 109;
    localparam int TMO     = 2048;
    localparam int LATENCY = 1038;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rises = 0;
    int rdy_cyc = 0;
    int ferr_cnt = 0;
    int t_start = 0;
    int exp_rises = 0;
    logic prev_rdy = 1'b0;
    logic [23:0] exp_q[$];

    uart_cmd_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_rdy && !prev_rdy) begin
            rises++;
            rdy_cyc = cyc;
            if (exp_q.size() == 0) chk("cmd_unexpected", 32'(exp_q.size()), 32'd1);
            else                   chk("cmd", {8'h0, cmd}, {8'h0, exp_q.pop_front()});
        end
        prev_rdy = cmd_rdy;
        if (frm_err) ferr_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        @(negedge clk);
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic send_cmd(input logic [23:0] c);
        exp_q.push_back(c);
        exp_rises++;
        send_byte(c[23:16], 1'b1);
        send_byte(c[15:8], 1'b1);
        send_byte(c[7:0], 1'b1);
    endtask

    initial begin
        int f0;
        int s;
        repeat (3) @(negedge clk);
        chk("reset_cmd", {8'h0, cmd}, 32'h0);
        chk("reset_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("reset_ferr", {31'h0, frm_err}, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Back-to-back command, latency from third start bit to cmd_rdy
        send_cmd(24'hA53C0F);
        chk("rdy_latency", 32'(rdy_cyc - t_start), 32'(LATENCY));
        chk("rises_1", 32'(rises), 32'(exp_rises));
        chk("cmd_hold", {8'h0, cmd}, 32'hA53C0F);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("clr_rdy", {31'h0, cmd_rdy}, 32'h0);

        // Short low glitch on idle line is a false start
        f0 = ferr_cnt;
        RX = 1'b0;
        repeat (20) @(negedge clk);
        RX = 1'b1;
        repeat (150) @(negedge clk);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);
        chk("glitch_bytecnt", {30'h0, dut.byte_cnt}, 32'h0);
        chk("glitch_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("glitch_idle", {31'h0, dut.u_rx.rx_idle}, 32'h1);

        // Frame error drops the partial command
        f0 = ferr_cnt;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        repeat (200) @(negedge clk);
        chk("ferr_pulse", 32'(ferr_cnt - f0), 32'h1);
        chk("ferr_bytecnt", {30'h0, dut.byte_cnt}, 32'h0);
        send_cmd(24'h56789A);
        chk("rises_2", 32'(rises), 32'(exp_rises));

        // Timeout discards a lone first byte
        send_byte(8'h11, 1'b1);
        repeat (TMO + 10) @(negedge clk);
        chk("tmo_bytecnt", {30'h0, dut.byte_cnt}, 32'h0);
        send_cmd(24'h223344);
        chk("rises_3", 32'(rises), 32'(exp_rises));

        // Acknowledge in the completion cycle: set wins
        exp_q.push_back(24'h010203);
        exp_rises++;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        fork
            send_byte(8'h03, 1'b1);
            begin
                @(negedge clk);
                s = cyc;
                repeat (LATENCY - 1) @(negedge clk);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                chk("set_wins", {31'h0, cmd_rdy}, 32'h1);
            end
        join
        chk("rises_4", 32'(rises), 32'(exp_rises));

        // Reset mid-byte after a completed first byte
        send_byte(8'h77, 1'b1);
        fork
            send_byte(8'h55, 1'b1);
            begin
                repeat (600) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk("rst_cmd", {8'h0, cmd}, 32'h0);
                chk("rst_rdy", {31'h0, cmd_rdy}, 32'h0);
                chk("rst_ferr", {31'h0, frm_err}, 32'h0);
            end
        join
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_cmd(24'hDEADBE);
        chk("rises_5", 32'(rises), 32'(exp_rises));
        chk("final_cmd", {8'h0, cmd}, 32'hDEADBE);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
